// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use and RAW interlocks, branch flush, memory waits, halt drain.
// Define PIPE_CTRL_FWD_EN when the datapath forwards results, so only load-use hazards stall.
module pipe_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       idex_memread,
    input  logic       idex_wreg,
    input  logic [2:0] idex_rd,
    input  logic [2:0] exmem_rd,
    input  logic       exmem_wreg,
    input  logic [2:0] ifid_rs,
    input  logic [2:0] ifid_rt,
    input  logic       ifid_use_rs,
    input  logic       ifid_use_rt,
    input  logic       br_taken,
    input  logic       id_halt,
    input  logic       id_err,
    input  logic       imem_stall,
    input  logic       dmem_stall,
    input  logic       dmem_done,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       idex_bubble,
    output logic       ifid_flush,
    output logic       mem_hold,
    output logic       halted,
    output logic       err_out,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        MWAIT = 2'b01,
        DRAIN = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t     st;
    logic [1:0] cnt;
    logic       br_lat;
    logic       hazard;
    logic       br_any;

    function automatic logic src_match(input logic [2:0] rd,
                                       input logic [2:0] rs, input logic use_rs,
                                       input logic [2:0] rt, input logic use_rt);
        return (use_rs && (rs == rd)) || (use_rt && (rt == rd));
    endfunction

`ifdef PIPE_CTRL_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{exmem_rd, exmem_wreg};
    assign hazard = idex_memread && idex_wreg &&
                    src_match(idex_rd, ifid_rs, ifid_use_rs, ifid_rt, ifid_use_rt);
`else
    // No forwarding: any pending write to a source register interlocks, r0 included.
    logic unused_fwd;
    assign unused_fwd = idex_memread;
    assign hazard = (idex_wreg  && src_match(idex_rd,  ifid_rs, ifid_use_rs, ifid_rt, ifid_use_rt)) ||
                    (exmem_wreg && src_match(exmem_rd, ifid_rs, ifid_use_rs, ifid_rt, ifid_use_rt));
`endif

    // A branch resolved while memory was busy is replayed on the first RUN cycle.
    assign br_any = br_taken || br_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= RUN;
            cnt     <= 2'd0;
            br_lat  <= 1'b0;
            err_out <= 1'b0;
        end else begin
            case (st)
                RUN: begin
                    if (dmem_stall) begin
                        st     <= MWAIT;
                        br_lat <= br_any;
                    end else if (br_any) begin
                        br_lat <= 1'b0;
                    end else if (!imem_stall && !hazard && (id_halt || id_err)) begin
                        st  <= DRAIN;
                        cnt <= 2'd3;
                        if (id_err) err_out <= 1'b1;
                    end
                end
                MWAIT: begin
                    if (br_taken)  br_lat <= 1'b1;
                    if (dmem_done) st     <= RUN;
                end
                DRAIN: begin
                    if (!dmem_stall) begin
                        if (cnt <= 2'd1) begin
                            st  <= HALT;
                            cnt <= 2'd0;
                        end else begin
                            cnt <= cnt - 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign state  = st;
    assign halted = (st == HALT);

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        mem_hold    = 1'b0;
        if (rst_n) begin
            case (st)
                RUN: begin
                    if (dmem_stall) begin
                        pc_we    = 1'b0;
                        ifid_we  = 1'b0;
                        mem_hold = 1'b1;
                    end else if (br_any) begin
                        idex_bubble = 1'b1;
                        ifid_flush  = 1'b1;
                    end else if (imem_stall || hazard || id_halt || id_err) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MWAIT: begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    mem_hold = 1'b1;
                end
                DRAIN: begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    mem_hold    = dmem_stall;
                end
                default: begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

endmodule
